// File: rtl/mult_hilo_seq_if.sv
// Bus bundle between the multiply sequencer, the control/datapath side
// and the Booth multiplier.
interface mult_hilo_seq_if;
    logic        Start;
    logic [31:0] RegAIn;
    logic [31:0] RegBIn;
    logic        MultDone;
    logic [31:0] MultHIIn;
    logic [31:0] MultLOIn;
    logic        HIWrEn;
    logic        LOWrEn;
    logic [31:0] WrData;
    logic        MultCtrl;
    logic [31:0] MultAOut;
    logic [31:0] MultBOut;
    logic [31:0] HIOut;
    logic [31:0] LOOut;
    logic        Busy;
    logic        Done;
    logic        Error;

    modport slave (
        input  Start, RegAIn, RegBIn, MultDone, MultHIIn, MultLOIn,
               HIWrEn, LOWrEn, WrData,
        output MultCtrl, MultAOut, MultBOut, HIOut, LOOut, Busy, Done, Error
    );

    modport master (
        output Start, RegAIn, RegBIn, MultDone, MultHIIn, MultLOIn,
               HIWrEn, LOWrEn, WrData,
        input  MultCtrl, MultAOut, MultBOut, HIOut, LOOut, Busy, Done, Error
    );
endinterface

// File: rtl/mult_hilo_seq.sv
// Multiply sequencer plus HI/LO register pair: holds operands for the Booth
// multiplier, captures its product, serves mthi/mtlo and stalls via Busy.
module mult_hilo_seq #(
    parameter int unsigned TIMEOUT = 48,
    parameter int unsigned CNT_W   = 8
) (
    input  logic           clock,
    input  logic           reset,
    mult_hilo_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ctrl_q,  ctrl_d;
    logic [31:0]      a_q,     a_d;
    logic [31:0]      b_q,     b_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.HIWrEn) hi_d = bus.WrData;
                if (bus.LOWrEn) lo_d = bus.WrData;
                if (bus.Start) begin
                    a_d     = bus.RegAIn;
                    b_d     = bus.RegBIn;
                    ctrl_d  = 1'b1;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.MultDone) begin
                    hi_d    = bus.MultHIIn;
                    lo_d    = bus.MultLOIn;
                    ctrl_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FLUSH;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    ctrl_d  = 1'b0;
                    state_d = S_FLUSH;
                end
            end

            S_FLUSH: begin
                // Wait here until the multiplier has dropped its done flag
                done_d = 1'b0;
                if (!bus.MultDone) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                ctrl_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.MultCtrl = ctrl_q;
    assign bus.MultAOut = a_q;
    assign bus.MultBOut = b_q;
    assign bus.HIOut    = hi_q;
    assign bus.LOOut    = lo_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Error    = err_q;

endmodule
